// File: rtl/sbox_word_sched.sv
// Shares one byte-wide AES sbox between key expansion (id 0) and round substitution (id 1),
// one byte per cycle. Define SBOX_SCHED_PIPE_EN to register sbox_o before capture.
module sbox_word_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_word0,
    input  logic [31:0] req_word1,
    output logic [7:0]  sbox_lhs,
    input  logic [7:0]  sbox_o,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_word
);

`ifdef SBOX_SCHED_PIPE_EN
    localparam logic [2:0] IDX_LAST = 3'd4;
`else
    localparam logic [2:0] IDX_LAST = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, SUB, RESP} state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic        prio_q;
    logic        id_q;
    logic [31:0] word_q;
    logic [31:0] res_q;

    logic        gnt_id;
    logic        accept;
    logic        cap_en;
    logic [2:0]  cap_idx;
    logic [7:0]  cap_byte;

    // Byte 0 is the most significant byte; out-of-range indices read as zero.
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (i == 3'(k)) b = w[8*(3-k) +: 8];
        end
        return b;
    endfunction

    always_comb begin
        gnt_id    = (req_valid == 2'b11) ? prio_q : req_valid[1];
        accept    = (state_q == IDLE) && (req_valid != 2'b00);
        req_ready = 2'b00;
        if (accept) req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    always_comb begin
        sbox_lhs = 8'h00;
        if (state_q == SUB) sbox_lhs = byte_of(word_q, idx_q);
    end

`ifdef SBOX_SCHED_PIPE_EN
    logic [7:0] sbox_p1;

    always_ff @(posedge clk) begin
        sbox_p1 <= sbox_o;
    end

    // Capture lags presentation by one cycle, so the first SUB cycle writes nothing.
    always_comb begin
        cap_en   = (state_q == SUB) && (idx_q != 3'd0);
        cap_idx  = idx_q - 3'd1;
        cap_byte = sbox_p1;
    end
`else
    always_comb begin
        cap_en   = (state_q == SUB);
        cap_idx  = idx_q;
        cap_byte = sbox_o;
    end
`endif

    always_ff @(posedge clk) begin
        if (accept) word_q <= gnt_id ? req_word1 : req_word0;
        if (cap_en) begin
            for (int k = 0; k < 4; k++) begin
                if (cap_idx == 3'(k)) res_q[8*(3-k) +: 8] <= cap_byte;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        id_q    <= gnt_id;
                        prio_q  <= ~gnt_id;
                        idx_q   <= 3'd0;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    if (idx_q == IDX_LAST) state_q <= RESP;
                    else                   idx_q   <= idx_q + 3'd1;
                end
                RESP: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Response fields are forced to zero outside RESP so reset clears them without resetting data.
    always_comb begin
        rsp_valid = (state_q == RESP);
        rsp_id    = rsp_valid & id_q;
        rsp_word  = rsp_valid ? res_q : 32'h0;
    end

endmodule

// File: tb/tb_sbox_word_sched.sv
// Bench for sbox_word_sched: vector table, hand-written corner sequences and a randomized
// phase checked against a transaction-level model. The sbox is computed from GF(2^8) arithmetic.
module tb_sbox_word_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [31:0] req_word0 = 32'h0;
    logic [31:0] req_word1 = 32'h0;
    logic [7:0]  sbox_lhs;
    logic [7:0]  sbox_o;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [31:0] rsp_word;

`ifdef SBOX_SCHED_PIPE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif
    localparam int GAP    = LAT + 1;
    localparam int SUBLEN = LAT - 1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbox_word_sched dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_word0(req_word0), .req_word1(req_word1),
        .sbox_lhs(sbox_lhs), .sbox_o(sbox_o),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_word(rsp_word)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254, then the AES affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]), aes_sbox(w[15:8]), aes_sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] w, input int i);
        logic [31:0] t;
        t = w >> (8 * (3 - i));
        return t[7:0];
    endfunction

    assign sbox_o = aes_sbox(sbox_lhs);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        string       nm;
        logic [1:0]  vld;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        eid;
        logic [31:0] ew;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int c;
        logic [31:0] w;
        w = v.eid ? v.w1 : v.w0;
        req_valid = v.vld; req_word0 = v.w0; req_word1 = v.w1;
        #1;
        chk({v.nm, " req_ready"}, 32'(req_ready), v.eid ? 32'd2 : 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        c = 1;
        while (!rsp_valid && c < 30) begin
            if (c <= 4) chk({v.nm, " sbox_lhs"}, 32'(sbox_lhs), 32'(byte_at(w, c - 1)));
            else        chk({v.nm, " sbox_lhs idle"}, 32'(sbox_lhs), 32'h0);
            @(negedge clk);
            c++;
        end
        chk({v.nm, " latency"}, 32'(c), 32'(LAT));
        chk({v.nm, " rsp_id"}, 32'(rsp_id), 32'(v.eid));
        chk({v.nm, " rsp_word"}, rsp_word, v.ew);
        @(negedge clk);
        chk({v.nm, " rsp done"}, 32'(rsp_valid), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, prev, seen;
        logic eid;
        logic [31:0] held_word;
        logic        held_id;
        logic        m_free, m_resp, m_prio, g, exp_id;
        int          m_cnt;
        logic [1:0]  hs, expr;
        logic [31:0] exp_word;

        vecs[0] = '{"v0",   2'b01, 32'h00010203, 32'h0,        1'b0, 32'h637c777b};
        vecs[1] = '{"v1",   2'b10, 32'h0,        32'h53535353, 1'b1, 32'hedededed};
        vecs[2] = '{"v2",   2'b01, 32'h00000000, 32'hffffffff, 1'b0, 32'h63636363};
        vecs[3] = '{"v3",   2'b10, 32'h0,        32'h102030ff, 1'b1, 32'hcab70416};
        vecs[4] = '{"v4",   2'b01, 32'h405060f0, 32'h0,        1'b0, 32'h0953d08c};
        vecs[5] = '{"v5",   2'b01, 32'hffffffff, 32'h0,        1'b0, 32'h16161616};

        do_reset();
        #1;
        chk("reset req_ready", 32'(req_ready), 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_id", 32'(rsp_id), 32'h0);
        chk("reset rsp_word", rsp_word, 32'h0);
        chk("reset sbox_lhs", 32'(sbox_lhs), 32'h0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both requesters held valid from reset: alternating grants, fixed spacing.
        do_reset();
        req_word0 = 32'h00000000; req_word1 = 32'h53535353; req_valid = 2'b11;
        prev = 0; eid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            c = 0;
            while (!rsp_valid && c < 20) begin
                @(negedge clk);
                c++;
            end
            chk("fair rsp_valid", 32'(rsp_valid), 32'h1);
            chk("fair rsp_id", 32'(rsp_id), 32'(eid));
            chk("fair rsp_word", rsp_word, eid ? 32'hedededed : 32'h63636363);
            if (k > 0) chk("fair spacing", 32'(cyc - prev), 32'(GAP));
            prev = cyc;
            eid  = ~eid;
            @(negedge clk);
        end
        req_valid = 2'b00;

        // Back-pressure: response must hold while both requesters are kept waiting.
        do_reset();
        rsp_ready = 1'b0; req_word0 = 32'h00010203; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        c = 0;
        while (!rsp_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        held_word = rsp_word; held_id = rsp_id;
        chk("bp first word", held_word, 32'h637c777b);
        req_valid = 2'b11; req_word1 = 32'h11111111;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("bp rsp_valid", 32'(rsp_valid), 32'h1);
            chk("bp rsp_word", rsp_word, 32'h637c777b);
            chk("bp rsp_id", 32'(rsp_id), 32'(held_id));
            chk("bp req_ready", 32'(req_ready), 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1; req_valid = 2'b00;
        @(negedge clk);
        chk("bp completion", 32'(rsp_valid), 32'h0);

        // Reset while the third byte is being presented.
        do_reset();
        req_word0 = 32'h01020304; req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst idx2 sbox_lhs", 32'(sbox_lhs), 32'h03);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst sbox_lhs", 32'(sbox_lhs), 32'h0);
        chk("rst rsp_word", rsp_word, 32'h0);
        chk("rst rsp_id", 32'(rsp_id), 32'h0);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst no response", 32'(seen), 32'h0);
        req_valid = 2'b11;
        #1;
        chk("rst prio cleared", 32'(req_ready), 32'h1);
        req_valid = 2'b00;

        // Randomized traffic against a transaction-level model.
        do_reset();
        m_free = 1'b1; m_resp = 1'b0; m_cnt = 0; m_prio = 1'b0;
        hs = 2'b00; exp_id = 1'b0; exp_word = 32'h0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] || hs[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    if (i == 0) req_word0 = $urandom;
                    else        req_word1 = $urandom;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            g    = (req_valid == 2'b11) ? m_prio : req_valid[1];
            expr = (m_free && req_valid != 2'b00) ? (g ? 2'b10 : 2'b01) : 2'b00;
            chk("rnd req_ready", 32'(req_ready), 32'(expr));
            chk("rnd rsp_valid", 32'(rsp_valid), 32'(m_resp));
            if (m_resp) begin
                chk("rnd rsp_id", 32'(rsp_id), 32'(exp_id));
                chk("rnd rsp_word", rsp_word, exp_word);
            end
            hs = 2'b00;
            if (m_free && req_valid != 2'b00) begin
                hs       = g ? 2'b10 : 2'b01;
                m_free   = 1'b0;
                m_cnt    = SUBLEN;
                m_prio   = ~g;
                exp_id   = g;
                exp_word = subword(g ? req_word1 : req_word0);
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_resp = 1'b1;
            end else if (m_resp && rsp_ready) begin
                m_resp = 1'b0;
                m_free = 1'b1;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sbox_word_sched.md
# sbox_word_sched

Time-multiplexing controller that shares one byte-wide `sbox` instance between two word-level requesters of the AES cipher: requester 0 is key expansion (`subWord`) and requester 1 is round state substitution. The block arbitrates between the requesters and latches the chosen 4-byte word. It feeds the bytes through the external `sbox` one per cycle, then returns the substituted word on a single response channel tagged with the requester id. It is a reduced-area alternative to instantiating four `sbox` copies per word.

## Interface
Parameters:
- none (byte count fixed at 4, byte width fixed at 8)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  2  per-requester request valid; bit 0 = key expansion, bit 1 = round
- `req_ready`  out  2  per-requester request ready
- `req_word0`  in  32  requester 0 word; byte 0 = [31:24], byte 3 = [7:0]
- `req_word1`  in  32  requester 1 word, same byte order
- `sbox_lhs`  out  8  byte presented to the shared combinational `sbox`
- `sbox_o`  in  8  `sbox` result for `sbox_lhs`
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  1  requester that owns the response
- `rsp_word`  out  32  substituted word, same byte order as the request

## Operation
- FSM states: IDLE, SUB, RESP.
- IDLE:
  - `req_ready[i]` = 1 only for the granted requester, and only when that requester's `req_valid[i]` = 1.
  - On handshake: latch the word into `word_q`, latch the id into `id_q`, clear `idx` to 0, go to SUB.
- Arbitration is round-robin:
  - Pointer `prio` resets to 0.
  - If both requesters are valid, `prio` wins.
  - If only one is valid, it wins.
  - After every grant, `prio` = granted id ^ 1.
- SUB:
  - `sbox_lhs` = byte `idx` of `word_q`.
  - Each cycle the `sbox` result is written into byte `idx` of `res_q`.
  - `idx` increments 0→3; after byte 3 the FSM goes to RESP.
- RESP:
  - `rsp_valid` = 1, `rsp_word` = `res_q`, `rsp_id` = `id_q`.
  - On `rsp_ready`, go to IDLE.
  - There is no same-cycle re-grant: IDLE is always visited for at least one cycle.
- Outside SUB, `sbox_lhs` = 0.
- `rsp_word` and `rsp_id` hold their values while `rsp_valid` = 1 and `rsp_ready` = 0.
- Requests are never dropped. A non-granted valid requester keeps waiting with `req_ready` = 0.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_word` = 0, `sbox_lhs` = 0.
  - FSM = IDLE, `prio` = 0, `idx` = 0.
- `req_ready` is combinational from `req_valid`, `prio` and state.
- Let the accept edge be cycle 0:
  - SUB occupies cycles 1–4, with `sbox_lhs` = bytes 0, 1, 2, 3 in that order.
  - `rsp_valid` rises in cycle 5.
- Minimum issue interval is 6 cycles per word, which includes the mandatory IDLE cycle.
- `rst` asserted in any state:
  - Next cycle the block is in IDLE with all reset values restored.
  - Any in-flight word is discarded, with no response.
- Behaviour when `req_valid` drops before the handshake is unspecified for the requester, but the block tolerates it: no grant is taken.

## Configuration
- Macro: `SBOX_SCHED_PIPE_EN`.
- Defined: a register is inserted on `sbox_o` before it is written into `res_q`, for timing closure of the `sbox` path.
  - SUB lasts 5 cycles: cycle 1 presents byte 0, and cycle 5 captures byte 3.
  - `rsp_valid` rises in cycle 6.
  - Minimum issue interval is 7 cycles.
  - `sbox_lhs` is 0 in the fifth SUB cycle.
- Undefined: combinational capture with the timing given above.

## Test plan
- Single word:
  - Stimulus: reset, then `req_valid` = 01, `req_word0` = 32'h00010203.
  - Required: `rsp_valid` in cycle 5, `rsp_id` = 0, `rsp_word` = 32'h637c777b, `sbox_lhs` sequence 00, 01, 02, 03.
- Simultaneous requests:
  - Stimulus: both valid from reset, with `req_word0` = 32'h00000000 and `req_word1` = 32'h53535353.
  - Required: grant 0 first (response 32'h63636363), then grant 1 (response 32'hedededed), responses 6 cycles apart.
- Fairness:
  - Stimulus: both requesters held valid for 8 words.
  - Required: grant order 0, 1, 0, 1, …; neither requester granted twice in a row.
- Back-pressure:
  - Stimulus: `rsp_ready` = 0 for 10 cycles after `rsp_valid` rises.
  - Required: `rsp_word` and `rsp_id` stable, `req_ready` = 2'b00 throughout, completion on the first `rsp_ready` = 1.
- Reset mid-operation:
  - Stimulus: `rst` asserted in SUB with `idx` = 2.
  - Required: next cycle IDLE, all outputs 0, no response ever emitted for that word.
- Pipeline option:
  - Stimulus: the single-word test with `SBOX_SCHED_PIPE_EN` defined.
  - Required: same `rsp_word`, with `rsp_valid` in cycle 6.
